avalon_pio_ext: RTL and testbench

AVALON_PIO_EXT -- requirements
Module: avalon_pio_ext

---
 rtl/avalon_pio_ext.sv | 181 ++++++++++++++++++
 tb/tb_avalon_pio_ext.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_ext.sv
// Avalon-MM parallel I/O port: output/direction registers, synchronized inputs,
// masked edge capture and an edge- or level-sourced interrupt.
module avalon_pio_ext #(
  parameter int              WIDTH       = 32,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT  = '0,
  parameter int              IRQ_MODE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_RISE   = 3'd6;
  localparam logic [2:0] ADDR_FALL   = 3'd7;

  // Last warm-up count before edge detection is enabled (SYNC_STAGES+1 cycles).
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } warm_state_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;

  warm_state_e      state_q, state_d;
  logic [2:0]       warm_cnt_q, warm_cnt_d;
  logic             edge_en;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] rise_hit;
  logic [WIDTH-1:0] fall_hit;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_d;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign wr_en   = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign sync_in = sync_p[SYNC_STAGES-1];
  assign pin_val = (dir_q & out_q) | (~dir_q & sync_in);

  // Input synchronizer stages and the one-cycle-delayed copy for edge compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p  <= '0;
      prev_in <= '0;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], in_port};
      prev_in <= sync_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WARM;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // The chain still holds reset zeros while it fills; ignore edges until flushed
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    edge_en    = 1'b0;
    case (state_q)
      WARM: begin
        warm_cnt_d = warm_cnt_q + 3'd1;
        if (warm_cnt_q == WARM_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        edge_en = 1'b1;
      end
      default: begin
        state_d = WARM;
      end
    endcase
  end

  assign rise_hit = sync_in & ~prev_in & rise_en_q & ~dir_q;
  assign fall_hit = ~sync_in & prev_in & fall_en_q & ~dir_q;
  assign edge_hit = edge_en ? (rise_hit | fall_hit) : '0;
  assign cap_clr  = (wr_en && address == ADDR_EDGE) ? wd : '0;

  // Register file; a new edge overrides a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= RESET_OUT;
      dir_q     <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= '1;
      fall_en_q <= '1;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:   out_q     <= wd;
          ADDR_DIR:    dir_q     <= wd;
          ADDR_MASK:   mask_q    <= wd;
          ADDR_OUTSET: out_q     <= out_q | wd;
          ADDR_OUTCLR: out_q     <= out_q & ~wd;
          ADDR_RISE:   rise_en_q <= wd;
          ADDR_FALL:   fall_en_q <= wd;
          default:     ;
        endcase
      end
      cap_q <= (cap_q & ~cap_clr) | edge_hit;
    end
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d = zext(pin_val);
      ADDR_DIR:  rd_d = zext(dir_q);
      ADDR_MASK: rd_d = zext(mask_q);
      ADDR_EDGE: rd_d = zext(cap_q);
      ADDR_RISE: rd_d = zext(rise_en_q);
      ADDR_FALL: rd_d = zext(fall_en_q);
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_d;
    end
  end

  assign out_port = out_q;
  assign oe_port  = dir_q;

  // Interrupt is a reduction of register outputs only
  generate
    if (IRQ_MODE == 0) begin : g_irq_edge
      assign irq = |(cap_q & mask_q);
    end else begin : g_irq_level
      assign irq = |(sync_in & ~dir_q & mask_q);
    end
  endgenerate

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Bench for avalon_pio_ext: directed scenarios plus randomized bus/pin traffic
// compared against a behavioural register-map model.
module tb_avalon_pio_ext;
  localparam int          S       = 2;
  localparam logic [31:0] RST_OUT = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, in_port;

  logic [31:0] rd_m, out_m, oe_m;
  logic        irq_m;
  logic [31:0] rd_l, out_l, oe_l;
  logic        irq_l;
  logic [31:0] rd_w;
  logic [7:0]  out_w, oe_w;
  logic        irq_w;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  avalon_pio_ext #(.WIDTH(32), .SYNC_STAGES(S), .RESET_OUT(RST_OUT), .IRQ_MODE(0)) dut_edge (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_m), .in_port(in_port),
    .out_port(out_m), .oe_port(oe_m), .irq(irq_m));

  avalon_pio_ext #(.WIDTH(32), .SYNC_STAGES(S), .RESET_OUT(32'h0), .IRQ_MODE(1)) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_l), .in_port(in_port),
    .out_port(out_l), .oe_port(oe_l), .irq(irq_l));

  avalon_pio_ext #(.WIDTH(8), .SYNC_STAGES(S), .RESET_OUT(8'h0), .IRQ_MODE(0)) dut_w8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_w), .in_port(in_port[7:0]),
    .out_port(out_w), .oe_port(oe_w), .irq(irq_w));

  // Reference model of the 32-bit edge-mode instance
  logic [31:0] m_out, m_dir, m_mask, m_cap, m_rise, m_fall, m_rd;
  logic [31:0] m_hist [0:S];
  logic [31:0] m_sync, m_prev, m_pin, m_edges;
  int          m_cycles;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out = RST_OUT; m_dir = '0; m_mask = '0; m_cap = '0;
      m_rise = '1; m_fall = '1; m_rd = '0; m_cycles = 0;
      for (int i = 0; i <= S; i++) m_hist[i] = '0;
    end else begin
      m_sync = m_hist[S-1];
      m_prev = m_hist[S];
      m_pin  = (m_dir & m_out) | (~m_dir & m_sync);
      case (address)
        3'd0: m_rd = m_pin;
        3'd1: m_rd = m_dir;
        3'd2: m_rd = m_mask;
        3'd3: m_rd = m_cap;
        3'd6: m_rd = m_rise;
        3'd7: m_rd = m_fall;
        default: m_rd = '0;
      endcase
      m_edges = '0;
      if (m_cycles > S)
        m_edges = ~m_dir & ((m_sync & ~m_prev & m_rise) | (~m_sync & m_prev & m_fall));
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out = writedata;
          3'd1: m_dir = writedata;
          3'd2: m_mask = writedata;
          3'd3: m_cap = m_cap & ~writedata;
          3'd4: m_out = m_out | writedata;
          3'd5: m_out = m_out & ~writedata;
          3'd6: m_rise = writedata;
          3'd7: m_fall = writedata;
          default: ;
        endcase
      end
      m_cap = m_cap | m_edges;
      for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = in_port;
      if (m_cycles < 1000) m_cycles++;
    end
  end

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic present(input logic [2:0] a);
    @(negedge clk);
    address = a;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (rd_m !== 32'h0) $display("FAIL reset_readdata got %h exp %h", rd_m, 32'h0); else passed++;
    checks++; if (out_m !== RST_OUT) $display("FAIL reset_out_port got %h exp %h", out_m, RST_OUT); else passed++;
    checks++; if (oe_m !== 32'h0) $display("FAIL reset_oe_port got %h exp %h", oe_m, 32'h0); else passed++;
    checks++; if (irq_m !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq_m); else passed++;
    reset_n = 1'b1;
    present(3'd6);
    checks++; if (rd_m !== 32'hFFFF_FFFF) $display("FAIL reset_rise_en got %h exp %h", rd_m, 32'hFFFF_FFFF); else passed++;
    present(3'd7);
    checks++; if (rd_m !== 32'hFFFF_FFFF) $display("FAIL reset_fall_en got %h exp %h", rd_m, 32'hFFFF_FFFF); else passed++;
    present(3'd2);
    checks++; if (rd_m !== 32'h0) $display("FAIL reset_irq_mask got %h exp %h", rd_m, 32'h0); else passed++;
    present(3'd3);
    checks++; if (rd_m !== 32'h0) $display("FAIL reset_edge_cap got %h exp %h", rd_m, 32'h0); else passed++;
  endtask

  task automatic test_set_clear();
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_000F);
    bus_write(3'd5, 32'h0000_0030);
    checks++; if (out_m !== 32'h0000_00CF) $display("FAIL set_clear_out got %h exp %h", out_m, 32'hCF); else passed++;
    checks++; if (out_w !== 8'hCF) $display("FAIL set_clear_out_w8 got %h exp %h", out_w, 8'hCF); else passed++;
    bus_write(3'd1, 32'h0000_00FF);
    checks++; if (oe_m !== 32'h0000_00FF) $display("FAIL set_clear_oe got %h exp %h", oe_m, 32'hFF); else passed++;
    present(3'd0);
    checks++; if (rd_m !== 32'h0000_00CF) $display("FAIL set_clear_read got %h exp %h", rd_m, 32'hCF); else passed++;
    present(3'd5);
    checks++; if (rd_m !== 32'h0) $display("FAIL outclr_reads_zero got %h exp %h", rd_m, 32'h0); else passed++;
  endtask

  task automatic test_edge_mask();
    in_port = '0;
    do_reset();
    repeat (S + 3) @(negedge clk);
    bus_write(3'd6, 32'h1);
    bus_write(3'd7, 32'h0);
    bus_write(3'd2, 32'h1);
    in_port = 32'h1;
    repeat (S) @(negedge clk);
    checks++; if (irq_m !== 1'b0) $display("FAIL edge_early_irq got %b exp 0", irq_m); else passed++;
    @(negedge clk);
    checks++; if (irq_m !== 1'b1) $display("FAIL edge_capture_irq got %b exp 1", irq_m); else passed++;
    in_port = 32'h0;
    address = 3'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    idle();
    checks++; if (irq_m !== 1'b0) $display("FAIL edge_w1c_irq got %b exp 0", irq_m); else passed++;
    repeat (S + 3) @(negedge clk);
    checks++; if (irq_m !== 1'b0) $display("FAIL fall_masked_irq got %b exp 0", irq_m); else passed++;
    present(3'd3);
    checks++; if (rd_m !== 32'h0) $display("FAIL fall_masked_cap got %h exp %h", rd_m, 32'h0); else passed++;
  endtask

  task automatic test_collision();
    in_port = 32'h1;
    @(negedge clk);
    @(negedge clk);
    address = 3'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    idle();
    checks++; if (irq_m !== 1'b1) $display("FAIL collision_irq got %b exp 1", irq_m); else passed++;
    present(3'd3);
    checks++; if (rd_m !== 32'h1) $display("FAIL collision_cap got %h exp %h", rd_m, 32'h1); else passed++;
  endtask

  task automatic test_reset_inputs_high();
    in_port = 32'hFFFF_FFFF;
    do_reset();
    repeat (2 * S + 6) @(negedge clk);
    present(3'd3);
    checks++; if (rd_m !== 32'h0) $display("FAIL warmup_cap got %h exp %h", rd_m, 32'h0); else passed++;
    checks++; if (rd_w !== 32'h0) $display("FAIL warmup_cap_w8 got %h exp %h", rd_w, 32'h0); else passed++;
    present(3'd0);
    checks++; if (rd_m !== 32'hFFFF_FFFF) $display("FAIL pin_read got %h exp %h", rd_m, 32'hFFFF_FFFF); else passed++;
  endtask

  task automatic test_level();
    in_port = '0;
    do_reset();
    repeat (S + 3) @(negedge clk);
    bus_write(3'd2, 32'h8);
    in_port = 32'h8;
    repeat (S - 1) @(negedge clk);
    checks++; if (irq_l !== 1'b0) $display("FAIL level_early_irq got %b exp 0", irq_l); else passed++;
    @(negedge clk);
    checks++; if (irq_l !== 1'b1) $display("FAIL level_irq got %b exp 1", irq_l); else passed++;
    bus_write(3'd1, 32'h8);
    checks++; if (irq_l !== 1'b0) $display("FAIL level_dir_irq got %b exp 0", irq_l); else passed++;
    checks++; if (oe_l !== 32'h8) $display("FAIL level_oe got %h exp %h", oe_l, 32'h8); else passed++;
  endtask

  task automatic test_width8();
    bus_write(3'd2, 32'hFFFF_FFFF);
    present(3'd2);
    checks++; if (rd_w !== 32'h0000_00FF) $display("FAIL w8_mask_read got %h exp %h", rd_w, 32'hFF); else passed++;
    checks++; if (rd_m !== 32'hFFFF_FFFF) $display("FAIL w32_mask_read got %h exp %h", rd_m, 32'hFFFF_FFFF); else passed++;
    bus_write(3'd4, 32'hFFFF_FFFF);
    present(3'd4);
    checks++; if (rd_w !== 32'h0) $display("FAIL w8_outset_read got %h exp %h", rd_w, 32'h0); else passed++;
    checks++; if (out_w !== 8'hFF) $display("FAIL w8_outset got %h exp %h", out_w, 8'hFF); else passed++;
  endtask

  task automatic test_random();
    logic exp_irq;
    in_port = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_irq = |(m_cap & m_mask);
      checks++; if (rd_m !== m_rd) $display("FAIL rand_readdata cyc %0d got %h exp %h", c, rd_m, m_rd); else passed++;
      checks++; if (out_m !== m_out) $display("FAIL rand_out_port cyc %0d got %h exp %h", c, out_m, m_out); else passed++;
      checks++; if (oe_m !== m_dir) $display("FAIL rand_oe_port cyc %0d got %h exp %h", c, oe_m, m_dir); else passed++;
      checks++; if (irq_m !== exp_irq) $display("FAIL rand_irq cyc %0d got %b exp %b", c, irq_m, exp_irq); else passed++;
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ $urandom;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_mid_reset();
    in_port = 32'h0000_0F00;
    bus_write(3'd1, 32'h0000_FFFF);
    bus_write(3'd0, 32'hFFFF_0000);
    bus_write(3'd2, 32'h0000_FFFF);
    present(3'd1);
    @(negedge clk);
    address = 3'd0; writedata = 32'hAAAA_AAAA; chipselect = 1'b1; write_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rd_m !== 32'h0) $display("FAIL midrst_readdata got %h exp %h", rd_m, 32'h0); else passed++;
    checks++; if (out_m !== RST_OUT) $display("FAIL midrst_out_port got %h exp %h", out_m, RST_OUT); else passed++;
    checks++; if (oe_m !== 32'h0) $display("FAIL midrst_oe_port got %h exp %h", oe_m, 32'h0); else passed++;
    checks++; if (irq_l !== 1'b0) $display("FAIL midrst_irq_lvl got %b exp 0", irq_l); else passed++;
    checks++; if (oe_w !== 8'h0) $display("FAIL midrst_oe_w8 got %h exp %h", oe_w, 8'h0); else passed++;
    @(negedge clk);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_m !== RST_OUT) $display("FAIL midrst_discard got %h exp %h", out_m, RST_OUT); else passed++;
    checks++; if (irq_m !== 1'b0) $display("FAIL midrst_irq got %b exp 0", irq_m); else passed++;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    test_reset();
    test_set_clear();
    test_edge_mask();
    test_collision();
    test_reset_inputs_high();
    test_level();
    test_width8();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
